// File: rtl/mux8_rr_arbiter.sv
// Eight-way round-robin arbiter with bounded per-winner bursts, feeding a
// single-entry valid/ready output stage that also reports the chosen source.
module mux8_rr_arbiter #(
    parameter int DW    = 4,
    parameter int BURST = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      req,
    input  logic [8*DW-1:0] din,
    output logic [7:0]      gnt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_sel
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_t          state_q;
    logic [2:0]      ptr_q;
    logic [3:0]      cnt_q;
    logic [7:0]      gnt_q;
    logic [DW-1:0]   data_q;
    logic [2:0]      sel_q;

    logic            load;
    logic [2:0]      win;
    logic [2:0]      idx;
    logic [3:0]      new_cnt;

    assign load = (|req) && (state_q == IDLE || out_ready);

    // Scan farthest-to-nearest from ptr so the nearest requester lands last.
    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (req[idx]) win = idx;
        end
    end

    assign new_cnt = (win == ptr_q) ? cnt_q + 4'd1 : 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            gnt_q <= '0;
            if (load) begin
                state_q <= HOLD;
                gnt_q   <= 8'b1 << win;
                data_q  <= din[win*DW +: DW];
                sel_q   <= win;
                if (new_cnt == BURST_C) begin
                    ptr_q <= win + 3'd1;
                    cnt_q <= '0;
                end else begin
                    ptr_q <= win;
                    cnt_q <= new_cnt;
                end
            end else if (state_q == HOLD && out_ready) begin
                state_q <= IDLE;
            end
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));
    a_gnt_after_load: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt != 8'd0) |-> $past(load));
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sel)));

endmodule
